// File: rtl/syncounter_up_mod.sv
// syncounter_up_mod: programmable-modulus synchronous up counter.
// Counts 0..mod_val and wraps to 0, with synchronous clear/load, a zero-latency
// cascade carry, a registered one-cycle wrap pulse and a sticky wrap flag.
// Build option: define SYNCOUNTER_UP_SATURATE_EN to make the counter stop at
// mod_val instead of wrapping (default build wraps).
module syncounter_up_mod #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] count_out,
    output logic             carry_out,
    output logic             wrap_pulse,
    output logic             wrapped
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             pulse_q, pulse_d;
    logic             wrapped_q, wrapped_d;
    logic             at_term;

    // Terminal detect is unsigned and also covers counts parked above mod_val
    // (after a load or after mod_val is lowered), so the counter never runs past it.
    assign at_term = (count_q >= mod_val);

    // Cascade enable for the next stage; zero latency so stages tick together.
    assign carry_out = enable & at_term;

    // Next-state selection in priority order: clear, load, count/terminal, hold.
    always_comb begin
        count_d   = count_q;
        pulse_d   = 1'b0;
        wrapped_d = wrapped_q;
        if (clear) begin
            count_d   = RESET_VAL;
            wrapped_d = 1'b0;
        end else if (load) begin
            count_d = load_val;
        end else if (enable) begin
            if (!at_term) begin
                // count_q < mod_val here, so the increment cannot overflow.
                count_d = count_q + 1'b1;
`ifdef SYNCOUNTER_UP_SATURATE_EN
                if (count_d == mod_val) begin
                    pulse_d   = 1'b1;
                    wrapped_d = 1'b1;
                end
`endif
            end else begin
`ifdef SYNCOUNTER_UP_SATURATE_EN
                // Clamp and park at the terminal value; no pulse while parked.
                count_d = mod_val;
`else
                // Wrap always returns to 0, independent of RESET_VAL.
                count_d   = '0;
                pulse_d   = 1'b1;
                wrapped_d = 1'b1;
`endif
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= RESET_VAL;
            pulse_q   <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pulse_q   <= pulse_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign count_out  = count_q;
    assign wrap_pulse = pulse_q;
    assign wrapped    = wrapped_q;

endmodule

// File: tb/tb_syncounter_up_mod.sv
// Testbench for syncounter_up_mod: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural model.
module tb_syncounter_up_mod;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable, clear, load;
    logic [W-1:0] load_val, mod_val;
    logic [W-1:0] count_out;
    logic         carry_out, wrap_pulse, wrapped;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_on = 1'b0;

    // Behavioural reference state
    int m_cnt;
    bit m_pulse;
    bit m_wrapped;

    syncounter_up_mod #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .load(load), .load_val(load_val), .mod_val(mod_val),
        .count_out(count_out), .carry_out(carry_out),
        .wrap_pulse(wrap_pulse), .wrapped(wrapped)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: the counter's rules stated as plain integer arithmetic.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cnt <= 0; m_pulse <= 1'b0; m_wrapped <= 1'b0;
        end else if (clear) begin
            m_cnt <= 0; m_pulse <= 1'b0; m_wrapped <= 1'b0;
        end else if (load) begin
            m_cnt <= int'(load_val); m_pulse <= 1'b0;
        end else if (enable && m_cnt < int'(mod_val)) begin
            m_cnt <= m_cnt + 1;
`ifdef SYNCOUNTER_UP_SATURATE_EN
            m_pulse <= (m_cnt + 1 == int'(mod_val));
            if (m_cnt + 1 == int'(mod_val)) m_wrapped <= 1'b1;
`else
            m_pulse <= 1'b0;
`endif
        end else if (enable) begin
`ifdef SYNCOUNTER_UP_SATURATE_EN
            m_cnt <= int'(mod_val); m_pulse <= 1'b0;
`else
            m_cnt <= 0; m_pulse <= 1'b1; m_wrapped <= 1'b1;
`endif
        end else begin
            m_pulse <= 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clock) begin
        #1;
        if (cmp_on) begin
            chk("model_count", int'(count_out), m_cnt);
            chk("model_pulse", int'(wrap_pulse), int'(m_pulse));
            chk("model_wrapped", int'(wrapped), int'(m_wrapped));
            chk("model_carry", int'(carry_out), int'(enable && (m_cnt >= int'(mod_val))));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; clear = 1'b0; load = 1'b0;
        load_val = '0; mod_val = 8'hFF;

        // Reset held with enable high
        repeat (10) cyc();
        chk("rst_count", int'(count_out), 0);
        chk("rst_pulse", int'(wrap_pulse), 0);
        chk("rst_wrapped", int'(wrapped), 0);
        chk("rst_carry", int'(carry_out), 0);
        cmp_on = 1'b1;

        // Release with enable low
        reset = 1'b1; enable = 1'b0;
        repeat (2) cyc();
        chk("release_hold", int'(count_out), 0);

        // Basic count
        enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk("basic_count", int'(count_out), i);
        end
        enable = 1'b0;
        cyc();
        chk("basic_hold", int'(count_out), 10);
        chk("basic_hold_carry", int'(carry_out), 0);

        // Modulus wrap at 4
        clear = 1'b1; cyc(); clear = 1'b0;
        mod_val = 8'h04; enable = 1'b1;
        begin
            int exp_seq [6] = '{1, 2, 3, 4, 0, 1};
            for (int i = 0; i < 6; i++) begin
                cyc();
                chk("mod4_seq", int'(count_out), exp_seq[i]);
                if (i == 3) chk("mod4_carry", int'(carry_out), 1);
                if (i == 4) chk("mod4_pulse", int'(wrap_pulse), 1);
                if (i == 5) begin
                    chk("mod4_pulse_once", int'(wrap_pulse), 0);
                    chk("mod4_sticky", int'(wrapped), 1);
                end
            end
        end

        // Priority: load beats enable, then clear beats load
        clear = 1'b1; cyc(); clear = 1'b0;
        mod_val = 8'h10;
        repeat (3) cyc();
        chk("prio_pre", int'(count_out), 3);
        load = 1'b1; load_val = 8'h20;
        cyc();
        chk("prio_load", int'(count_out), 32);
        load = 1'b0;
        cyc();
        chk("prio_wrap", int'(count_out), 0);
        chk("prio_wrap_pulse", int'(wrap_pulse), 1);
        clear = 1'b1; load = 1'b1;
        cyc();
        chk("prio_clear", int'(count_out), 0);
        chk("prio_clear_wrapped", int'(wrapped), 0);
        clear = 1'b0; load = 1'b0;

        // Mid-operation asynchronous reset
        mod_val = 8'hFF;
        repeat (7) cyc();
        chk("midrst_pre", int'(count_out), 7);
        #1 reset = 1'b0;
        #1 chk("midrst_async", int'(count_out), 0);
        cyc();
        reset = 1'b1;

        // mod_val = 0: stuck at 0, pulse every enabled cycle
        mod_val = 8'h00;
        repeat (3) begin
            cyc();
            chk("mod0_count", int'(count_out), 0);
`ifndef SYNCOUNTER_UP_SATURATE_EN
            chk("mod0_pulse", int'(wrap_pulse), 1);
`endif
        end

        // mod_val lowered below current count
        clear = 1'b1; cyc(); clear = 1'b0;
        mod_val = 8'hFF;
        repeat (10) cyc();
        mod_val = 8'h05;
        cyc();
`ifdef SYNCOUNTER_UP_SATURATE_EN
        chk("lower_sat", int'(count_out), 5);
`else
        chk("lower_wrap", int'(count_out), 0);
`endif

        // Full-range wrap 255 -> 0
        load = 1'b1; load_val = 8'hFE; mod_val = 8'hFF; cyc(); load = 1'b0;
        cyc();
        chk("full_255", int'(count_out), 255);
        cyc();
`ifdef SYNCOUNTER_UP_SATURATE_EN
        chk("full_sat", int'(count_out), 255);
`else
        chk("full_wrap", int'(count_out), 0);
`endif

`ifdef SYNCOUNTER_UP_SATURATE_EN
        // Saturation at 3
        clear = 1'b1; cyc(); clear = 1'b0;
        mod_val = 8'h03;
        begin
            int pulses = 0;
            int sat_seq [8] = '{1, 2, 3, 3, 3, 3, 3, 3};
            for (int i = 0; i < 8; i++) begin
                cyc();
                chk("sat_seq", int'(count_out), sat_seq[i]);
                pulses += int'(wrap_pulse);
            end
            chk("sat_pulse_once", pulses, 1);
        end
        load = 1'b1; load_val = 8'h00; cyc(); load = 1'b0;
        cyc();
        chk("sat_resume", int'(count_out), 1);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enable   = ($urandom_range(0, 9) < 8);
            clear    = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 29) == 0);
            load_val = W'($urandom);
            if ($urandom_range(0, 39) == 0)
                mod_val = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 12)) : W'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #1 reset = 1'b0;
                #1 chk("rand_async_rst", int'(count_out), 0);
            end else begin
                reset = 1'b1;
            end
            cyc();
        end
        reset = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
